divu_seq: RTL and testbench

Sequential 32-bit unsigned divider. It implements the DIVU operation (funct 6'b011011) that the combinational ALU cannot execute in one cycle. The divider is radix-2 restoring: one quotient bit is produced per clock. It sits beside the 32-bit ALU in the execute stage, shares the ALU's dataA/dataB/Signal operand bus, and returns quotient and remainder for the HI/LO registers.

---
 rtl/divu_seq_if.sv | 23 ++
 rtl/divu_seq.sv | 110 +++++++++++
 tb/tb_divu_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divu_seq_if.sv
// Operand/result bundle between the execute-stage requester and the sequential divider.
// master drives operands and start; slave returns status and the HI/LO results.
interface divu_seq_if;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        start;
    logic        busy;
    logic        done;
    logic        divZero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output dataA, dataB, Signal, start,
        input  busy, done, divZero, quotient, remainder
    );

    modport slave (
        input  dataA, dataB, Signal, start,
        output busy, done, divZero, quotient, remainder
    );
endinterface

// File: rtl/divu_seq.sv
// Radix-2 restoring unsigned divider: done pulses 33 cycles after an accepted start (1 cycle for /0).
// No backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module divu_seq (
    input  logic       clk,
    input  logic       reset,
    divu_seq_if.slave  bus
);
    localparam logic [5:0] DIVU = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] q_q;
    logic [31:0] d_q;
    // Partial remainder always stays below the divisor, so 32 stored bits suffice.
    logic [31:0] r_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        divzero_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;

    logic [32:0] s_d;
    logic [32:0] t_d;
    logic [31:0] r_d;
    logic [31:0] q_d;

    always_comb begin
        s_d = {r_q, q_q[31]};
        t_d = s_d - {1'b0, d_q};
        if (!t_d[32]) begin
            r_d = t_d[31:0];
            q_d = {q_q[30:0], 1'b1};
        end else begin
            r_d = s_d[31:0];
            q_d = {q_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && (bus.Signal == DIVU)) begin
                        q_q       <= bus.dataA;
                        d_q       <= bus.dataB;
                        r_q       <= '0;
                        cnt_q     <= '0;
                        divzero_q <= 1'b0;
                        if (bus.dataB != 32'd0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            // Divide by zero finishes immediately with all-ones quotient.
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            divzero_q <= 1'b1;
                            quot_q    <= 32'hFFFF_FFFF;
                            rem_q     <= bus.dataA;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divZero   = divzero_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: expected results queued at start, popped on done.
module tb_divu_seq;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] ADD  = 6'b100000;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    divu_seq_if bus();

    divu_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    task automatic test_reset();
        reset = 1'b1;
        bus.dataA = 32'd100;
        bus.dataB = 32'd7;
        bus.Signal = DIVU;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
        total_cnt++;
        if (bus.divZero !== 1'b0) $display("FAIL reset_divZero got=%b exp=0", bus.divZero); else pass_cnt++;
        total_cnt++;
        if (bus.quotient !== 32'd0) $display("FAIL reset_quotient got=%h exp=0", bus.quotient); else pass_cnt++;
        total_cnt++;
        if (bus.remainder !== 32'd0) $display("FAIL reset_remainder got=%h exp=0", bus.remainder); else pass_cnt++;
        bus.start = 1'b0;
        reset = 1'b0;
        prev_q = '0;
        prev_r = '0;
    endtask

    // Called at a negedge; returns at the negedge of the earliest cycle a new start may be sampled.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit hold, input string name);
        exp_t e;
        exp_t got;
        int   exp_cyc;
        int   done_cyc;
        int   done_cnt;
        int   busy_bad;
        int   overlap;
        e.q  = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        e.r  = (b == 32'd0) ? a : a % b;
        e.dz = (b == 32'd0);
        sb.push_back(e);
        exp_cyc  = (b == 32'd0) ? 1 : 33;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        overlap  = 0;
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = DIVU;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy !== ((b != 32'd0 && k <= 32) ? 1'b1 : 1'b0)) busy_bad++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0 && sb.size() > 0) begin
                    done_cyc = k;
                    got = sb.pop_front();
                    total_cnt++;
                    if (bus.quotient !== got.q)
                        $display("FAIL %s_quotient got=%h exp=%h", name, bus.quotient, got.q);
                    else pass_cnt++;
                    total_cnt++;
                    if (bus.remainder !== got.r)
                        $display("FAIL %s_remainder got=%h exp=%h", name, bus.remainder, got.r);
                    else pass_cnt++;
                    total_cnt++;
                    if (bus.divZero !== got.dz)
                        $display("FAIL %s_divZero got=%b exp=%b", name, bus.divZero, got.dz);
                    else pass_cnt++;
                end
            end else if (k == 16 && b != 32'd0) begin
                total_cnt++;
                if (bus.quotient !== prev_q || bus.remainder !== prev_r)
                    $display("FAIL %s_hold_during_run got=%h/%h exp=%h/%h", name,
                             bus.quotient, bus.remainder, prev_q, prev_r);
                else pass_cnt++;
            end
            if (done_cyc > 0 && k == done_cyc + 1) begin
                total_cnt++;
                if (bus.divZero !== e.dz)
                    $display("FAIL %s_divZero_held got=%b exp=%b", name, bus.divZero, e.dz);
                else pass_cnt++;
            end
            if (hold && k <= exp_cyc) begin
                bus.dataA = 32'd9;
                bus.dataB = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (done_cyc > 0 && k == done_cyc + 1) break;
        end
        bus.start = 1'b0;
        if (done_cyc < 0 && sb.size() > 0) void'(sb.pop_back());
        total_cnt++;
        if (done_cyc != exp_cyc)
            $display("FAIL %s_done_cycle got=%0d exp=%0d (-1 = timeout)", name, done_cyc, exp_cyc);
        else pass_cnt++;
        total_cnt++;
        if (busy_bad != 0) $display("FAIL %s_busy_profile bad_cycles=%0d exp=0", name, busy_bad); else pass_cnt++;
        total_cnt++;
        if (overlap != 0 || done_cnt != 1)
            $display("FAIL %s_done_pulse overlap=%0d pulses=%0d exp=0/1", name, overlap, done_cnt);
        else pass_cnt++;
        prev_q = e.q;
        prev_r = e.r;
    endtask

    task automatic test_normal();
        run_div(32'd100, 32'd7, 1'b0, "normal");
    endtask

    task automatic test_div_one();
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "div_one");
    endtask

    task automatic test_small_dividend();
        run_div(32'd3, 32'd10, 1'b0, "small_dividend");
    endtask

    task automatic test_large_divisor();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "large_divisor");
    endtask

    task automatic test_div_zero();
        run_div(32'd5, 32'd0, 1'b0, "div_zero");
    endtask

    task automatic test_reset_mid_run();
        int spurious;
        spurious = 0;
        bus.dataA  = 32'd100;
        bus.dataB  = 32'd7;
        bus.Signal = DIVU;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) spurious++;
            if (k == 10) reset = 1'b1;
            if (k == 11) begin
                total_cnt++;
                if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else pass_cnt++;
                total_cnt++;
                if (bus.quotient !== 32'd0) $display("FAIL midrst_quotient got=%h exp=0", bus.quotient); else pass_cnt++;
                total_cnt++;
                if (bus.remainder !== 32'd0) $display("FAIL midrst_remainder got=%h exp=0", bus.remainder); else pass_cnt++;
                reset = 1'b0;
            end
        end
        total_cnt++;
        if (spurious != 0 || bus.busy !== 1'b0)
            $display("FAIL midrst_no_done pulses=%0d busy=%b exp=0/0", spurious, bus.busy);
        else pass_cnt++;
        prev_q = '0;
        prev_r = '0;
    endtask

    task automatic test_ignored_starts();
        int bad;
        bad = 0;
        run_div(32'd100, 32'd7, 1'b1, "start_during_run");
        bus.dataA  = 32'd50;
        bus.dataB  = 32'd5;
        bus.Signal = ADD;
        bus.start  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        bus.start = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL add_ignored_activity bad_cycles=%0d exp=0", bad); else pass_cnt++;
        total_cnt++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2)
            $display("FAIL add_ignored_result got=%0d/%0d exp=14/2", bus.quotient, bus.remainder);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        run_div(32'd5, 32'd0, 1'b0, "b2b_zero");
        run_div(32'd1000, 32'd10, 1'b0, "b2b_after_zero");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_div(a, b, 1'b0, "b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_div_one();
        test_small_dividend();
        test_large_divisor();
        test_div_zero();
        test_reset_mid_run();
        test_ignored_starts();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
